// File: rtl/wave_ram_pkg.sv
// Shared types and constants for the wave RAM arbiter: RAM geometry,
// grant/owner encodings and a saturating counter helper.
package wave_ram_pkg;

  localparam int WAVE_ADDR_W = 11;
  localparam int WAVE_DATA_W = 9;
  localparam int MISS_CNT_W  = 8;

  // Who owns the RAM port in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE    = 2'd0,
    GNT_PB      = 2'd1,
    GNT_HOST_RD = 2'd2,
    GNT_HOST_WR = 2'd3
  } grant_e;

  // Which requester the read data on ram_dout belongs to this cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_PB   = 2'd1,
    OWN_HOST = 2'd2
  } rd_owner_e;

  // 8-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    logic [7:0] res;
    if (val == 8'hFF) begin
      res = val;
    end else begin
      res = val + 8'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/wave_ram_arbiter.sv
// Single-port wave RAM arbiter. Playback reads have priority; the host loader
// gets idle slots and is forced through after STARVE_MAX blocked cycles, at the
// cost of one dropped playback read (reported via pb_miss / pb_miss_cnt).
// Read data comes straight from the RAM one cycle after the grant.
module wave_ram_arbiter
  import wave_ram_pkg::*;
#(
  parameter int ADDR_W     = WAVE_ADDR_W,
  parameter int DATA_W     = WAVE_DATA_W,
  parameter int STARVE_MAX = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pb_req,
  input  logic [ADDR_W-1:0]     pb_addr,
  output logic                  pb_valid,
  output logic [DATA_W-1:0]     pb_data,
  output logic                  pb_miss,
  output logic [MISS_CNT_W-1:0] pb_miss_cnt,
  input  logic                  miss_clr,
  input  logic                  host_valid,
  output logic                  host_ready,
  input  logic                  host_we,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [DATA_W-1:0]     host_wdata,
  output logic                  host_rvalid,
  output logic [DATA_W-1:0]     host_rdata,
  output logic                  ram_ce,
  output logic                  ram_oce,
  output logic                  ram_wre,
  output logic [ADDR_W-1:0]     ram_ad,
  output logic [DATA_W-1:0]     ram_din,
  input  logic [DATA_W-1:0]     ram_dout
);

  localparam logic [7:0] STARVE_MAX_C = 8'(STARVE_MAX);

  grant_e                  grant_s;
  rd_owner_e               rd_owner_r;
  logic [7:0]              starve_cnt_r;
  logic                    starved_s;
  logic                    host_xfer_s;
  logic                    override_s;
  logic                    pb_miss_r;
  logic [MISS_CNT_W-1:0]   pb_miss_cnt_r;

  assign starved_s   = (starve_cnt_r == STARVE_MAX_C);
  assign host_xfer_s = host_valid && host_ready;

  // Host acceptance and starvation override detection for this cycle.
  always_comb begin
    host_ready = 1'b0;
    override_s = 1'b0;
    if (reset) begin
      host_ready = 1'b0;
      override_s = 1'b0;
    end else begin
      host_ready = !pb_req || starved_s;
      override_s = starved_s && pb_req && host_valid;
    end
  end

  // Per-cycle grant: playback first unless the host has waited too long.
  always_comb begin
    grant_s = GNT_NONE;
    if (reset) begin
      grant_s = GNT_NONE;
    end else if (pb_req && !starved_s) begin
      grant_s = GNT_PB;
    end else if (host_valid) begin
      grant_s = host_we ? GNT_HOST_WR : GNT_HOST_RD;
    end else begin
      grant_s = GNT_NONE;
    end
  end

  // Drive the Gowin_SP port from the grant; idle address/data held at zero.
  always_comb begin
    ram_ce  = 1'b0;
    ram_wre = 1'b0;
    ram_ad  = {ADDR_W{1'b0}};
    ram_din = {DATA_W{1'b0}};
    case (grant_s)
      GNT_PB: begin
        ram_ce = 1'b1;
        ram_ad = pb_addr;
      end
      GNT_HOST_WR: begin
        ram_ce  = 1'b1;
        ram_wre = 1'b1;
        ram_ad  = host_addr;
        ram_din = host_wdata;
      end
      GNT_HOST_RD: begin
        ram_ce = 1'b1;
        ram_ad = host_addr;
      end
      default: begin
        ram_ce  = 1'b0;
        ram_wre = 1'b0;
      end
    endcase
  end

  // Remember which requester issued the read so its data can be tagged next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_owner_r <= OWN_NONE;
    end else begin
      case (grant_s)
        GNT_PB:      rd_owner_r <= OWN_PB;
        GNT_HOST_RD: rd_owner_r <= OWN_HOST;
        default:     rd_owner_r <= OWN_NONE;
      endcase
    end
  end

  // Count consecutive cycles the host has been held off, capped at STARVE_MAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt_r <= 8'd0;
    end else if (!host_valid || host_xfer_s) begin
      starve_cnt_r <= 8'd0;
    end else if (starve_cnt_r < STARVE_MAX_C) begin
      starve_cnt_r <= starve_cnt_r + 8'd1;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Flag and count playback reads dropped by the override; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pb_miss_r     <= 1'b0;
      pb_miss_cnt_r <= 8'd0;
    end else begin
      pb_miss_r <= override_s;
      if (miss_clr) begin
        pb_miss_cnt_r <= 8'd0;
      end else if (override_s) begin
        pb_miss_cnt_r <= sat_inc8(pb_miss_cnt_r);
      end else begin
        pb_miss_cnt_r <= pb_miss_cnt_r;
      end
    end
  end

  assign pb_valid    = (rd_owner_r == OWN_PB);
  assign host_rvalid = (rd_owner_r == OWN_HOST);
  assign pb_data     = ram_dout;
  assign host_rdata  = ram_dout;
  assign pb_miss     = pb_miss_r;
  assign pb_miss_cnt = pb_miss_cnt_r;
  assign ram_oce     = 1'b1;

endmodule

// File: tb/tb_wave_ram_arbiter.sv
// Bench for wave_ram_arbiter: a behavioural RAM stands in for Gowin_SP, and a
// reference model (shadow memory + blocked-cycle count) predicts every output.
module tb_wave_ram_arbiter;

  localparam int STARVE_MAX = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        pb_req;
  logic [10:0] pb_addr;
  logic        pb_valid;
  logic [8:0]  pb_data;
  logic        pb_miss;
  logic [7:0]  pb_miss_cnt;
  logic        miss_clr;
  logic        host_valid;
  logic        host_ready;
  logic        host_we;
  logic [10:0] host_addr;
  logic [8:0]  host_wdata;
  logic        host_rvalid;
  logic [8:0]  host_rdata;
  logic        ram_ce;
  logic        ram_oce;
  logic        ram_wre;
  logic [10:0] ram_ad;
  logic [8:0]  ram_din;
  logic [8:0]  ram_dout = 9'd0;

  int n_checks = 0;
  int n_errors = 0;

  wave_ram_arbiter #(.ADDR_W(11), .DATA_W(9), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .pb_req(pb_req), .pb_addr(pb_addr), .pb_valid(pb_valid), .pb_data(pb_data),
    .pb_miss(pb_miss), .pb_miss_cnt(pb_miss_cnt), .miss_clr(miss_clr),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM, bypass output: data appears the cycle after ce.
  logic [8:0] ram_mem [2048];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_wre) begin
        ram_mem[ram_ad] <= ram_din;
        ram_dout        <= ram_din;
      end else begin
        ram_dout <= ram_mem[ram_ad];
      end
    end
  end

  // Reference model state.
  logic [8:0] shadow [2048];
  int         m_wait = 0;
  logic       m_pb_valid = 1'b0;
  logic       m_host_rvalid = 1'b0;
  logic [8:0] m_rdata = 9'd0;
  logic       m_miss = 1'b0;
  int         m_cnt = 0;

  // Samples taken at the last negedge, for the hand-written checks.
  logic       s_host_ready, s_pb_valid, s_host_rvalid, s_pb_miss, s_ram_ce, s_ram_wre;
  logic [8:0] s_pb_data, s_host_rdata;
  logic [7:0] s_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle with the inputs currently applied; checks everything against the model.
  task automatic run_cycle();
    logic        starved, exp_ready, pb_win, host_go;
    logic        e_ce, e_wre;
    logic [10:0] e_ad;
    logic [8:0]  e_din;
    starved   = (m_wait == STARVE_MAX);
    exp_ready = !reset && (!pb_req || starved);
    pb_win    = !reset && pb_req && !starved;
    host_go   = !reset && host_valid && exp_ready;
    e_ce = pb_win || host_go;
    e_wre = host_go && host_we;
    e_ad = pb_win ? pb_addr : (host_go ? host_addr : 11'd0);
    e_din = e_wre ? host_wdata : 9'd0;

    @(negedge clk);
    s_host_ready = host_ready; s_pb_valid = pb_valid; s_host_rvalid = host_rvalid;
    s_pb_miss = pb_miss; s_ram_ce = ram_ce; s_ram_wre = ram_wre;
    s_pb_data = pb_data; s_host_rdata = host_rdata; s_cnt = pb_miss_cnt;

    chk("host_ready", 32'(host_ready), 32'(exp_ready));
    chk("ram_ce", 32'(ram_ce), 32'(e_ce));
    chk("ram_wre", 32'(ram_wre), 32'(e_wre));
    chk("ram_ad", 32'(ram_ad), 32'(e_ad));
    chk("ram_din", 32'(ram_din), 32'(e_din));
    chk("ram_oce", 32'(ram_oce), 32'd1);
    if (reset) begin
      chk("pb_valid_rst", 32'(pb_valid), 32'd0);
      chk("host_rvalid_rst", 32'(host_rvalid), 32'd0);
      chk("pb_miss_rst", 32'(pb_miss), 32'd0);
      chk("miss_cnt_rst", 32'(pb_miss_cnt), 32'd0);
    end else begin
      chk("pb_valid", 32'(pb_valid), 32'(m_pb_valid));
      chk("host_rvalid", 32'(host_rvalid), 32'(m_host_rvalid));
      chk("pb_miss", 32'(pb_miss), 32'(m_miss));
      chk("miss_cnt", 32'(pb_miss_cnt), 32'(m_cnt));
      if (m_pb_valid) chk("pb_data", 32'(pb_data), 32'(m_rdata));
      if (m_host_rvalid) chk("host_rdata", 32'(host_rdata), 32'(m_rdata));
    end

    @(posedge clk);
    if (reset) begin
      m_wait = 0; m_pb_valid = 1'b0; m_host_rvalid = 1'b0; m_miss = 1'b0; m_cnt = 0;
    end else begin
      m_pb_valid    = pb_win;
      m_host_rvalid = host_go && !host_we;
      if (pb_win) m_rdata = shadow[pb_addr];
      else if (host_go && !host_we) m_rdata = shadow[host_addr];
      if (host_go && host_we) shadow[host_addr] = host_wdata;
      m_miss = starved && pb_req && host_valid;
      if (miss_clr) m_cnt = 0;
      else if (m_miss && m_cnt < 255) m_cnt = m_cnt + 1;
      if (!host_valid || host_go) m_wait = 0;
      else if (m_wait < STARVE_MAX) m_wait = m_wait + 1;
    end
    #1;
  endtask

  typedef struct {
    logic rst; logic pb; logic [10:0] pa; logic hv; logic we; logic [10:0] ha; logic [8:0] hd;
    logic rdy; logic ce; logic wre; logic pbv; logic hrv; logic [8:0] dat;
  } vec_t;
  vec_t tbl [15];

  initial begin
    bit found;

    // Reset rows, playback burst over 0..7, host write then read-back of 0x7FF.
    for (int i = 0; i < 3; i++)
      tbl[i] = '{1'b1, 1'b1, 11'd0, 1'b1, 1'b0, 11'd0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    tbl[3] = '{1'b0, 1'b1, 11'd0, 1'b0, 1'b0, 11'd0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0};
    for (int k = 1; k < 8; k++)
      tbl[3+k] = '{1'b0, 1'b1, 11'(k), 1'b0, 1'b0, 11'd0, 9'd0,
                   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9'(9'h100 + 9'(k) - 9'd1)};
    tbl[11] = '{1'b0, 1'b0, 11'd0, 1'b1, 1'b1, 11'h7FF, 9'h1A5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 9'h107};
    tbl[12] = '{1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 11'h7FF, 9'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0};
    tbl[13] = '{1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h1A5};
    tbl[14] = '{1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 11'd0, 9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0};

    // Preload the RAM contents with word = addr + 0x100.
    for (int a = 0; a < 2048; a++) ram_mem[a] = 9'(a + 256);
    // The model's view of the same preload.
    for (int a = 0; a < 2048; a++) shadow[a] = 9'(a + 256);

    reset = 1'b1; pb_req = 1'b1; pb_addr = 11'd0; host_valid = 1'b1; host_we = 1'b0;
    host_addr = 11'd0; host_wdata = 9'd0; miss_clr = 1'b0;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < 15; i++) begin
      reset = tbl[i].rst; pb_req = tbl[i].pb; pb_addr = tbl[i].pa; host_valid = tbl[i].hv;
      host_we = tbl[i].we; host_addr = tbl[i].ha; host_wdata = tbl[i].hd;
      run_cycle();
      chk("vec_ready", 32'(s_host_ready), 32'(tbl[i].rdy));
      chk("vec_ce", 32'(s_ram_ce), 32'(tbl[i].ce));
      chk("vec_wre", 32'(s_ram_wre), 32'(tbl[i].wre));
      chk("vec_pb_valid", 32'(s_pb_valid), 32'(tbl[i].pbv));
      chk("vec_host_rvalid", 32'(s_host_rvalid), 32'(tbl[i].hrv));
      if (tbl[i].pbv) chk("vec_pb_data", 32'(s_pb_data), 32'(tbl[i].dat));
      if (tbl[i].hrv) chk("vec_host_rdata", 32'(s_host_rdata), 32'(tbl[i].dat));
      if (tbl[i].rst) chk("vec_cnt_rst", 32'(s_cnt), 32'd0);
    end

    // Contention: host blocked for STARVE_MAX cycles, forced through, one pb read lost.
    pb_req = 1'b0; host_valid = 1'b0; miss_clr = 1'b1;
    run_cycle();
    miss_clr = 1'b0;
    for (int c = 0; c <= 16; c++) begin
      pb_req = 1'b1; pb_addr = 11'($urandom_range(0, 2047));
      host_valid = 1'b1; host_we = 1'b0; host_addr = 11'($urandom_range(0, 2047));
      run_cycle();
      chk("cont_ready", 32'(s_host_ready), (c == 15) ? 32'd1 : 32'd0);
      if (c == 16) begin
        chk("cont_miss", 32'(s_pb_miss), 32'd1);
        chk("cont_pb_valid", 32'(s_pb_valid), 32'd0);
        chk("cont_cnt", 32'(s_cnt), 32'd1);
      end
    end

    // Idle-slot sharing: every pb_req=0 cycle serves the host, no overrides.
    pb_req = 1'b0; host_valid = 1'b0;
    run_cycle();
    for (int c = 0; c < 20; c++) begin
      pb_req = (c % 2 == 0); pb_addr = 11'($urandom_range(0, 15));
      host_valid = 1'b1; host_we = 1'($urandom_range(0, 1));
      host_addr = 11'($urandom_range(0, 15)); host_wdata = 9'($urandom_range(0, 511));
      run_cycle();
      if (!pb_req) chk("share_ready", 32'(s_host_ready), 32'd1);
      chk("share_no_miss", 32'(s_pb_miss), 32'd0);
    end

    // Reset while a playback read is in flight: its valid must never show.
    host_valid = 1'b0; pb_req = 1'b1; pb_addr = 11'd5;
    run_cycle();
    reset = 1'b1;
    run_cycle();
    chk("rst_mid_pb_valid", 32'(s_pb_valid), 32'd0);
    reset = 1'b0; pb_req = 1'b0;
    run_cycle();
    chk("rst_after_pb_valid", 32'(s_pb_valid), 32'd0);
    run_cycle();
    chk("rst_after2_pb_valid", 32'(s_pb_valid), 32'd0);

    // 300 forced overrides saturate the miss counter.
    for (int c = 0; c < 300 * 16 + 1; c++) begin
      pb_req = 1'b1; pb_addr = 11'($urandom_range(0, 15));
      host_valid = 1'b1; host_we = 1'($urandom_range(0, 1));
      host_addr = 11'($urandom_range(0, 15)); host_wdata = 9'($urandom_range(0, 511));
      run_cycle();
    end
    chk("cnt_saturated", 32'(s_cnt), 32'd255);

    // miss_clr landing on an override cycle leaves the counter at zero.
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      miss_clr = (m_wait == STARVE_MAX);
      found = miss_clr;
      run_cycle();
    end
    miss_clr = 1'b0;
    run_cycle();
    chk("clr_window_found", 32'(found), 32'd1);
    chk("clr_vs_miss_cnt", 32'(s_cnt), 32'd0);
    chk("clr_vs_miss_pulse", 32'(s_pb_miss), 32'd1);

    // Randomised traffic against the model, with occasional resets and clears.
    for (int c = 0; c < 800; c++) begin
      reset = ($urandom_range(0, 49) == 0);
      pb_req = 1'($urandom_range(0, 1)); pb_addr = 11'($urandom_range(0, 15));
      host_valid = 1'($urandom_range(0, 3) != 0); host_we = 1'($urandom_range(0, 1));
      host_addr = 11'($urandom_range(0, 15)); host_wdata = 9'($urandom_range(0, 511));
      miss_clr = ($urandom_range(0, 19) == 0);
      run_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
